// File: rtl/reg_status_file.sv
// Architectural register file with ROB rename-tag tracking: multi-port in-order
// commit, same-cycle commit-to-read bypass, and a flush that drops in-flight tags.
module reg_status_file #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int TAG_W   = 3,
  parameter int NCOMMIT = 1,
  parameter int RW      = $clog2(NREG)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pause,
  input  logic                      flush,
  input  logic [NCOMMIT-1:0]        commit_valid,
  input  logic [NCOMMIT*RW-1:0]     commit_reg,
  input  logic [NCOMMIT*TAG_W-1:0]  commit_tag,
  input  logic [NCOMMIT*XLEN-1:0]   commit_data,
  input  logic                      disp_valid,
  input  logic [RW-1:0]             disp_rs1,
  input  logic [RW-1:0]             disp_rs2,
  input  logic [RW-1:0]             disp_rd,
  input  logic [TAG_W-1:0]          disp_tag,
  output logic                      out_valid,
  output logic [XLEN-1:0]           out_val1,
  output logic [XLEN-1:0]           out_val2,
  output logic [TAG_W-1:0]          out_tag1,
  output logic [TAG_W-1:0]          out_tag2
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [TAG_W-1:0] dep_q  [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [TAG_W-1:0] dep_d  [NREG];

  logic [RW-1:0]    src     [2];
  logic [XLEN-1:0]  src_val [2];
  logic [TAG_W-1:0] src_tag [2];
  logic             accept;

  assign src[0] = disp_rs1;
  assign src[1] = disp_rs2;
  assign accept = disp_valid & ~flush;

  // Source lookup uses pre-update state; a commit retiring the exact producer
  // forwards its data. Ascending port order lets the youngest hit win.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_tag[s] = dep_q[src[s]];
      src_val[s] = regs_q[src[s]];
      if (dep_q[src[s]] != '0) begin
        for (int p = 0; p < NCOMMIT; p++) begin
          if (commit_valid[p] &&
              commit_reg[p*RW +: RW] == src[s] &&
              commit_tag[p*TAG_W +: TAG_W] == dep_q[src[s]]) begin
            src_tag[s] = '0;
            src_val[s] = commit_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    regs_d = regs_q;
    dep_d  = dep_q;
    for (int p = 0; p < NCOMMIT; p++) begin
      if (commit_valid[p] && commit_reg[p*RW +: RW] != '0) begin
        regs_d[commit_reg[p*RW +: RW]] = commit_data[p*XLEN +: XLEN];
        // A mismatching tag means a newer producer owns the register.
        if (dep_q[commit_reg[p*RW +: RW]] == commit_tag[p*TAG_W +: TAG_W])
          dep_d[commit_reg[p*RW +: RW]] = '0;
      end
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++)
        dep_d[r] = '0;
    end else if (disp_valid && disp_rd != '0) begin
      dep_d[disp_rd] = disp_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        dep_q[r]  <= '0;
      end
      out_valid <= 1'b0;
      out_val1  <= '0;
      out_val2  <= '0;
      out_tag1  <= '0;
      out_tag2  <= '0;
    end else if (!pause) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        dep_q[r]  <= dep_d[r];
      end
      out_valid <= accept;
      if (accept) begin
        out_val1 <= src_val[0];
        out_val2 <= src_val[1];
        out_tag1 <= src_tag[0];
        out_tag2 <= src_tag[1];
      end
    end
  end

endmodule
